// File: rtl/cnn_3d_result_streamer.sv
// Drains the 3D-convolution result buffer after each conv_done edge and streams
// scaled, rectified, saturated 8-bit features with valid/ready and map/frame markers.
module cnn_3d_result_streamer #(
  parameter int unsigned IMG_SIZE    = 6,
  parameter int unsigned FILT_SIZE   = 3,
  parameter int unsigned NUM_FILTERS = 3,
  parameter int unsigned SHIFT       = 0,
  parameter int unsigned RELU_EN     = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               conv_done,
  output logic               rd_en,
  output logic [15:0]        rd_addr,
  input  logic signed [15:0] rd_data,
  output logic signed [7:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         out_filter,
  output logic               out_last_map,
  output logic               out_last,
  output logic               busy,
  output logic               frame_done
);

  localparam int unsigned RS     = IMG_SIZE - FILT_SIZE + 1;
  localparam int unsigned VOL    = RS * RS * RS;
  localparam int unsigned TOTAL  = VOL * NUM_FILTERS;
  localparam int unsigned ELEM_W = (VOL > 1) ? $clog2(VOL) : 1;

  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, SEND, DONE} state_t;

  state_t              state;
  logic                done_q;
  logic [15:0]         idx;
  logic [ELEM_W-1:0]   elem;
  logic [1:0]          filt;

  logic signed [15:0]  shifted;
  logic signed [15:0]  rectified;
  logic signed [7:0]   sat_data;
  logic                elem_last;

  always_comb begin
    shifted   = rd_data >>> SHIFT;
    rectified = shifted;
    if ((RELU_EN != 0) && (shifted < 16'sd0)) rectified = '0;
    if (rectified > 16'sd127)       sat_data = 8'sd127;
    else if (rectified < -16'sd128) sat_data = -8'sd128;
    else                            sat_data = rectified[7:0];
  end

  assign elem_last = (elem == ELEM_W'(VOL - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      done_q       <= 1'b0;
      idx          <= '0;
      elem         <= '0;
      filt         <= '0;
      rd_en        <= 1'b0;
      rd_addr      <= '0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      out_filter   <= '0;
      out_last_map <= 1'b0;
      out_last     <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      done_q <= conv_done;
      case (state)
        IDLE: begin
          if (conv_done && !done_q) begin
            idx     <= '0;
            elem    <= '0;
            filt    <= '0;
            rd_en   <= 1'b1;
            rd_addr <= '0;
            busy    <= 1'b1;
            state   <= FETCH;
          end
        end
        FETCH: begin
          rd_en <= 1'b0;
          state <= CAPTURE;
        end
        CAPTURE: begin
          out_data     <= sat_data;
          out_filter   <= filt;
          out_last_map <= elem_last;
          out_last     <= elem_last && (filt == 2'(NUM_FILTERS - 1));
          out_valid    <= 1'b1;
          state        <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (idx == 16'(TOTAL - 1)) begin
              frame_done <= 1'b1;
              state      <= DONE;
            end else begin
              // elem/filt track idx so map position needs no divider
              idx     <= idx + 16'd1;
              rd_addr <= idx + 16'd1;
              rd_en   <= 1'b1;
              if (elem_last) begin
                elem <= '0;
                filt <= filt + 2'd1;
              end else begin
                elem <= elem + ELEM_W'(1);
              end
              state <= FETCH;
            end
          end
        end
        DONE: begin
          frame_done <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_3d_result_streamer.sv
// Bench for cnn_3d_result_streamer: three parameterisations run in lockstep against
// a buffer model and a per-element reference computed from index arithmetic.
module tb_cnn_3d_result_streamer;

  localparam int TOTAL = 192;
  localparam int VOL   = 64;

  logic clk = 1'b0;
  logic reset_n;
  logic conv_done;
  logic out_ready;

  logic               rd_en        [3];
  logic [15:0]        rd_addr      [3];
  logic signed [15:0] rd_data      [3];
  logic signed [7:0]  out_data     [3];
  logic               out_valid    [3];
  logic [1:0]         out_filter   [3];
  logic               out_last_map [3];
  logic               out_last     [3];
  logic               busy         [3];
  logic               frame_done   [3];

  logic signed [15:0] mem [TOTAL];

  int vectors = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  cnn_3d_result_streamer #(.SHIFT(0), .RELU_EN(1)) dut0 (
    .clk(clk), .reset_n(reset_n), .conv_done(conv_done), .rd_en(rd_en[0]), .rd_addr(rd_addr[0]),
    .rd_data(rd_data[0]), .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready),
    .out_filter(out_filter[0]), .out_last_map(out_last_map[0]), .out_last(out_last[0]),
    .busy(busy[0]), .frame_done(frame_done[0]));

  cnn_3d_result_streamer #(.SHIFT(0), .RELU_EN(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .conv_done(conv_done), .rd_en(rd_en[1]), .rd_addr(rd_addr[1]),
    .rd_data(rd_data[1]), .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready),
    .out_filter(out_filter[1]), .out_last_map(out_last_map[1]), .out_last(out_last[1]),
    .busy(busy[1]), .frame_done(frame_done[1]));

  cnn_3d_result_streamer #(.SHIFT(2), .RELU_EN(0)) dut2 (
    .clk(clk), .reset_n(reset_n), .conv_done(conv_done), .rd_en(rd_en[2]), .rd_addr(rd_addr[2]),
    .rd_data(rd_data[2]), .out_data(out_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready),
    .out_filter(out_filter[2]), .out_last_map(out_last_map[2]), .out_last(out_last[2]),
    .busy(busy[2]), .frame_done(frame_done[2]));

  // Result buffer: one-cycle read latency per instance.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 3; i++)
      if (rd_en[i]) rd_data[i] <= mem[rd_addr[i]];
  end

  function automatic int shift_of(input int unsigned i);
    return (i == 2) ? 2 : 0;
  endfunction

  function automatic logic signed [7:0] ref_val(input logic signed [15:0] d, input int unsigned i);
    int v;
    v = d;
    v = v >>> shift_of(i);
    if (i == 0 && v < 0) v = 0;
    if (v > 127) return 8'sd127;
    if (v < -128) return -8'sd128;
    return v[7:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    for (int unsigned i = 0; i < 3; i++) begin
      chk($sformatf("%s rd_en d%0d", tag, i), rd_en[i], 0);
      chk($sformatf("%s rd_addr d%0d", tag, i), rd_addr[i], 0);
      chk($sformatf("%s out_data d%0d", tag, i), out_data[i], 0);
      chk($sformatf("%s out_valid d%0d", tag, i), out_valid[i], 0);
      chk($sformatf("%s out_filter d%0d", tag, i), out_filter[i], 0);
      chk($sformatf("%s last_map d%0d", tag, i), out_last_map[i], 0);
      chk($sformatf("%s last d%0d", tag, i), out_last[i], 0);
      chk($sformatf("%s busy d%0d", tag, i), busy[i], 0);
      chk($sformatf("%s frame_done d%0d", tag, i), frame_done[i], 0);
    end
  endtask

  task automatic fill_random();
    for (int unsigned j = 0; j < TOTAL; j++) begin
      int v;
      if ($urandom_range(0, 1) != 0) v = $urandom_range(0, 65535) - 32768;
      else v = $urandom_range(0, 400) - 200;
      mem[j] = 16'(v);
    end
    mem[3] = -16'sd5;
    mem[4] = 16'sd1000;
    mem[7] = -16'sd1000;
    mem[9] = 16'sd77;
  endtask

  // mode 0: ready always; 1: 10-cycle stall at idx 5; 2: random ready.
  task automatic run_frame(input int mode, input bit pulse);
    int k, cyc, reads, first_fetch, first_valid, last_hs, stall;
    bit hs_prev;
    k = 0; cyc = 0; reads = 0; first_fetch = -1; first_valid = -1; last_hs = -1; stall = 0;
    hs_prev = 1'b0;
    conv_done = 1'b1;
    while (k < TOTAL && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (rd_en[0] === 1'b1 && first_fetch < 0) first_fetch = cyc;
      if (out_valid[0] === 1'b1 && first_valid < 0) first_valid = cyc;
      if (hs_prev) chk($sformatf("fetch_after_hs k%0d", k), rd_en[0], 1);
      for (int unsigned i = 0; i < 3; i++) begin
        chk($sformatf("busy d%0d k%0d", i, k), busy[i], 1);
        chk($sformatf("frame_done_early d%0d k%0d", i, k), frame_done[i], 0);
        if (rd_en[i] === 1'b1) begin
          chk($sformatf("rd_addr d%0d", i), rd_addr[i], k);
          chk($sformatf("rd_while_valid d%0d k%0d", i, k), out_valid[i], 0);
        end
        if (out_valid[0] === 1'b1) begin
          chk($sformatf("valid d%0d k%0d", i, k), out_valid[i], 1);
          chk($sformatf("data d%0d k%0d", i, k), out_data[i], ref_val(mem[k], i));
          chk($sformatf("filter d%0d k%0d", i, k), out_filter[i], k / VOL);
          chk($sformatf("last_map d%0d k%0d", i, k), out_last_map[i], (k % VOL) == VOL - 1);
          chk($sformatf("last d%0d k%0d", i, k), out_last[i], k == TOTAL - 1);
        end
      end
      if (rd_en[0] === 1'b1) reads++;
      case (mode)
        1: if (k == 5 && out_valid[0] === 1'b1 && stall < 10) begin
             out_ready = 1'b0;
             stall++;
           end else out_ready = 1'b1;
        2: out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b1;
      endcase
      if (pulse) conv_done = !(k >= 100 && k < 102);
      hs_prev = (out_valid[0] === 1'b1) && out_ready;
      if (hs_prev) begin
        if (k == TOTAL - 1) last_hs = cyc;
        k++;
      end
    end
    chk("frame_elements", k, TOTAL);
    chk("reads_per_frame", reads, TOTAL);
    chk("first_fetch_latency", first_fetch, 1);
    chk("first_valid_latency", first_valid, 3);
    if (mode == 0) chk("frame_cycles", last_hs - first_fetch + 1, 576);
    @(negedge clk);
    for (int unsigned i = 0; i < 3; i++) begin
      chk($sformatf("frame_done_pulse d%0d", i), frame_done[i], 1);
      chk($sformatf("busy_in_done d%0d", i), busy[i], 1);
      chk($sformatf("valid_dropped d%0d", i), out_valid[i], 0);
    end
    @(negedge clk);
    for (int unsigned i = 0; i < 3; i++) begin
      chk($sformatf("frame_done_single d%0d", i), frame_done[i], 0);
      chk($sformatf("busy_fall d%0d", i), busy[i], 0);
    end
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      chk($sformatf("%s busy c%0d", tag, c), busy[0], 0);
      chk($sformatf("%s rd_en c%0d", tag, c), rd_en[0], 0);
      chk($sformatf("%s frame_done c%0d", tag, c), frame_done[0], 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, cyc;
    for (int unsigned j = 0; j < TOTAL; j++) mem[j] = 16'(j);

    // Reset held with random inputs
    reset_n   = 1'b0;
    conv_done = 1'b0;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      conv_done = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
    end
    #1;
    chk_idle("reset");
    conv_done = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    idle_cycles("post_reset", 5);

    // Full frame, rd_data = idx
    run_frame(0, 1'b0);

    // Random data with directed arithmetic cases, backpressure at idx 5
    conv_done = 1'b0;
    @(negedge clk); @(negedge clk);
    fill_random();
    run_frame(1, 1'b0);

    // conv_done still high after the frame: no restart
    idle_cycles("held_high", 20);

    // Falling then rising edge restarts; a mid-frame pulse is ignored
    conv_done = 1'b0;
    @(negedge clk); @(negedge clk);
    fill_random();
    run_frame(2, 1'b1);
    idle_cycles("after_pulse", 10);

    // Reset mid-frame around idx 50
    conv_done = 1'b0;
    @(negedge clk); @(negedge clk);
    conv_done = 1'b1;
    out_ready = 1'b1;
    k = 0; cyc = 0;
    while (k < 50 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (out_valid[0] === 1'b1) k++;
    end
    chk("abort_reached", k, 50);
    @(negedge clk); @(negedge clk);
    chk("abort_busy_before", busy[0], 1);
    reset_n = 1'b0;
    #1;
    chk_idle("async_reset");
    conv_done = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    idle_cycles("after_abort", 10);
    fill_random();
    run_frame(0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
